program_counter: RTL

Byte-wide program counter with a small hardware return stack for the LittleComputer CPU. It sits directly downstream of the byte register: it holds the instruction address that drives the instruction memory. Each clock it holds, increments, jumps to a loaded value, calls (push return address and jump) or returns (pop).

---
 rtl/program_counter_pkg.sv | 35 +++
 rtl/program_counter_return_stack.sv | 73 +++++++
 rtl/program_counter.sv | 97 +++++++++
 3 files changed

// File: rtl/program_counter_pkg.sv
// Shared definitions for the LittleComputer program counter: default sizes and
// the action encoding produced by the command arbiter.
package program_counter_pkg;

    localparam int PC_WIDTH = 8;
    localparam int PC_DEPTH = 4;

    localparam logic [2:0] ACT_HOLD = 3'd0;
    localparam logic [2:0] ACT_INC  = 3'd1;
    localparam logic [2:0] ACT_LOAD = 3'd2;
    localparam logic [2:0] ACT_CALL = 3'd3;
    localparam logic [2:0] ACT_RET  = 3'd4;

    // Strict priority RET > CALL > LOAD > INC > HOLD; exactly one action wins.
    function automatic logic [2:0] pick_action(
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        logic [2:0] act;
        act = ACT_HOLD;
        if (ret) begin
            act = ACT_RET;
        end else if (call) begin
            act = ACT_CALL;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (inc) begin
            act = ACT_INC;
        end
        return act;
    endfunction

endpackage

// File: rtl/program_counter_return_stack.sv
// Hardware return stack: DEPTH x WIDTH entries, stack pointer and FULL/EMPTY
// decode. Everything clears asynchronously so reset is visible without a clock.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    // Push writes the slot at SP; the top of stack lives one below it.
    assign wr_idx  = sp_q[AW-1:0];
    assign top_idx = sp_q[AW-1:0] - AW'(1);

    always_comb begin
        sp_d = sp_q;
        if (push) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_comb begin
                stack_d[gi] = stack_q[gi];
                if (push && (wr_idx == AW'(gi))) begin
                    stack_d[gi] = din;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stack_q[gi] <= '0;
                end else begin
                    stack_q[gi] <= stack_d[gi];
                end
            end
        end
    endgenerate

    assign top   = stack_q[top_idx];
    assign sp    = sp_q;
    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);

endmodule

// File: rtl/program_counter.sv
// LittleComputer program counter: priority arbiter, PC register, +1 adder and
// sticky stack-fault flag around a small hardware return stack.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_DEPTH
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    INC,
    input  logic                    LOAD,
    input  logic                    CALL,
    input  logic                    RET,
    input  logic [WIDTH-1:0]        IN,
    output logic [WIDTH-1:0]        OUT,
    output logic [$clog2(DEPTH):0]  SP,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ERR
);

    logic [2:0]       action;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic             err_q;
    logic             err_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] stack_top;
    logic             stack_full;
    logic             stack_empty;

    assign action = pick_action(RET, CALL, LOAD, INC);
    assign pc_inc = pc_q + WIDTH'(1);

    // A faulting CALL/RET still consumes the cycle: nothing falls through.
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        push  = 1'b0;
        pop   = 1'b0;
        case (action)
            ACT_INC:  pc_d = pc_inc;
            ACT_LOAD: pc_d = IN;
            ACT_CALL: begin
                if (stack_full) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                    pc_d = IN;
                end
            end
            ACT_RET: begin
                if (stack_empty) begin
                    err_d = 1'b1;
                end else begin
                    pop  = 1'b1;
                    pc_d = stack_top;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_return_stack (
        .clk   (CLK),
        .rst_n (RSTn),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stack_top),
        .sp    (SP),
        .full  (stack_full),
        .empty (stack_empty)
    );

    assign OUT   = pc_q;
    assign FULL  = stack_full;
    assign EMPTY = stack_empty;
    assign ERR   = err_q;

endmodule
